// File: rtl/sr_axi_adapter_pkg.sv
// Shared types for the single-request AXI burst adapter: FSM states, AXI encodings,
// beat-size helper and the NoC master-port structs (same layout as axi_type.svh).
package sr_axi_adapter_pkg;

    localparam int unsigned AXI_ADDR_W = 16;
    localparam int unsigned AXI_DATA_W = 8;
    localparam int unsigned AXI_ID_W   = 4;

    localparam logic [1:0] INCR = 2'b01;
    localparam logic [1:0] OKAY = 2'b00;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWaitB,
        StReadAr,
        StReadR,
        StResp
    } state_e;

    typedef struct packed {
        logic [AXI_ID_W-1:0]     awid;
        logic [AXI_ADDR_W-1:0]   awaddr;
        logic [7:0]              awlen;
        logic [2:0]              awsize;
        logic [1:0]              awburst;
        logic                    awvalid;
        logic [AXI_DATA_W-1:0]   wdata;
        logic [AXI_DATA_W/8-1:0] wstrb;
        logic                    wlast;
        logic                    wvalid;
        logic                    bready;
        logic [AXI_ID_W-1:0]     arid;
        logic [AXI_ADDR_W-1:0]   araddr;
        logic [7:0]              arlen;
        logic [2:0]              arsize;
        logic [1:0]              arburst;
        logic                    arvalid;
        logic                    rready;
    } axi_mosi_t;

    typedef struct packed {
        logic                  awready;
        logic                  wready;
        logic [1:0]            bresp;
        logic                  bvalid;
        logic                  arready;
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rlast;
        logic                  rvalid;
    } axi_miso_t;

    // AxSIZE encoding for a beat of data_width bits
    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/sr_axi_burst_adapter_if.sv
// Core memory port plus NoC AXI master port of the burst adapter.
// slave = adapter side, master = core/NoC side.
interface sr_axi_burst_adapter_if
    import sr_axi_adapter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned MEM_DATA_WIDTH = 32
);
    logic                        mem_wr_i;
    logic [ADDR_WIDTH-1:0]       mem_addr_i;
    logic [MEM_DATA_WIDTH-1:0]   mem_wdata_i;
    logic [MEM_DATA_WIDTH/8-1:0] mem_wstrb_i;
    logic                        mem_req_valid_i;
    logic                        mem_req_ready_o;
    logic                        mem_resp_valid_o;
    logic                        mem_resp_ready_i;
    logic [MEM_DATA_WIDTH-1:0]   mem_rdata_o;
    logic                        mem_resp_err_o;
    axi_miso_t                   in_miso_i;
    axi_mosi_t                   in_mosi_o;

    modport slave (
        input  mem_wr_i, mem_addr_i, mem_wdata_i, mem_wstrb_i, mem_req_valid_i,
               mem_resp_ready_i, in_miso_i,
        output mem_req_ready_o, mem_resp_valid_o, mem_rdata_o, mem_resp_err_o, in_mosi_o
    );

    modport master (
        output mem_wr_i, mem_addr_i, mem_wdata_i, mem_wstrb_i, mem_req_valid_i,
               mem_resp_ready_i, in_miso_i,
        input  mem_req_ready_o, mem_resp_valid_o, mem_rdata_o, mem_resp_err_o, in_mosi_o
    );
endinterface

// File: rtl/sr_axi_beat_serdes.sv
// Beat counter with write-slice mux and read-slice write-back for one burst.
// The counter saturates at BEATS so surplus read beats are dropped.
module sr_axi_beat_serdes #(
    parameter int unsigned BEATS      = 4,
    parameter int unsigned BEAT_WIDTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr_i,
    input  logic                              w_adv_i,
    input  logic                              r_adv_i,
    input  logic [BEATS*BEAT_WIDTH-1:0]       wdata_i,
    input  logic [BEATS*BEAT_WIDTH/8-1:0]     wstrb_i,
    input  logic [BEAT_WIDTH-1:0]             r_beat_i,
    output logic [BEAT_WIDTH-1:0]             w_beat_o,
    output logic [BEAT_WIDTH/8-1:0]           w_strb_o,
    output logic                              last_beat_o,
    output logic [BEATS*BEAT_WIDTH-1:0]       rdata_o
);
    localparam int unsigned CNT_WIDTH = $clog2(BEATS + 1);
    localparam int unsigned STRB_W    = BEAT_WIDTH / 8;

    logic [CNT_WIDTH-1:0]        cnt_q;
    logic [BEATS*BEAT_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if ((w_adv_i || r_adv_i) && (cnt_q != CNT_WIDTH'(BEATS))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (r_adv_i) begin
            for (int k = 0; k < BEATS; k++) begin
                if (cnt_q == CNT_WIDTH'(k)) begin
                    rdata_q[k*BEAT_WIDTH +: BEAT_WIDTH] <= r_beat_i;
                end
            end
        end
    end

    always_comb begin
        w_beat_o = '0;
        w_strb_o = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (cnt_q == CNT_WIDTH'(k)) begin
                w_beat_o = wdata_i[k*BEAT_WIDTH +: BEAT_WIDTH];
                w_strb_o = wstrb_i[k*STRB_W +: STRB_W];
            end
        end
    end

    assign last_beat_o = (cnt_q == CNT_WIDTH'(BEATS - 1));
    assign rdata_o     = rdata_q;

endmodule

// File: rtl/sr_axi_burst_adapter.sv
// Converts one core memory request into a single INCR AXI burst and returns a held response.
// Define SR_AXI_ADAPTER_TIMEOUT_EN to add a watchdog that aborts a stalled burst with err=1.
module sr_axi_burst_adapter
    import sr_axi_adapter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned MEM_DATA_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 8,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned ID_SHIFT       = 12,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic                   clk,
    input logic                   rst,
    sr_axi_burst_adapter_if.slave bus
);
    localparam int unsigned BEATS = MEM_DATA_WIDTH / AXI_DATA_WIDTH;

    if (AXI_DATA_WIDTH < 8 || (AXI_DATA_WIDTH & (AXI_DATA_WIDTH - 1)) != 0 ||
        AXI_DATA_WIDTH != AXI_DATA_W) begin : g_bad_axi_width
        $error("AXI_DATA_WIDTH must be a power of two >= 8 matching the AXI structs");
    end
    if (MEM_DATA_WIDTH % AXI_DATA_WIDTH != 0 || BEATS == 0 || BEATS > 256) begin : g_bad_beats
        $error("MEM_DATA_WIDTH must be 1..256 whole AXI beats");
    end
    if (ADDR_WIDTH > AXI_ADDR_W || ID_WIDTH > AXI_ID_W || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("address/ID width exceeds AXI struct fields or TIMEOUT_CYCLES is zero");
    end

    state_e                      state_q, state_d;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [MEM_DATA_WIDTH-1:0]   wdata_q;
    logic [MEM_DATA_WIDTH/8-1:0] wstrb_q;
    logic                        aw_done_q, aw_done_d;
    logic                        w_done_q, w_done_d;
    logic                        err_q, err_d;

    logic                        req_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                        aw_valid, w_valid, ar_valid;
    logic                        last_beat, timeout;
    logic [ID_WIDTH-1:0]         axi_id;
    logic [AXI_DATA_WIDTH-1:0]   w_beat;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic [MEM_DATA_WIDTH-1:0]   rdata;
    axi_mosi_t                   mosi;

    // Valids come only from registered state so no AXI input reaches them combinationally
    assign aw_valid = (state_q == StWrite) && !aw_done_q;
    assign w_valid  = (state_q == StWrite) && !w_done_q;
    assign ar_valid = (state_q == StReadAr);

    assign req_hs = bus.mem_req_ready_o && bus.mem_req_valid_i;
    assign aw_hs  = aw_valid && bus.in_miso_i.awready;
    assign w_hs   = w_valid && bus.in_miso_i.wready;
    assign b_hs   = (state_q == StWaitB) && bus.in_miso_i.bvalid;
    assign ar_hs  = ar_valid && bus.in_miso_i.arready;
    assign r_hs   = (state_q == StReadR) && bus.in_miso_i.rvalid;

    assign axi_id = ID_WIDTH'(addr_q >> ID_SHIFT) + ID_WIDTH'(1);

    sr_axi_beat_serdes #(
        .BEATS      (BEATS),
        .BEAT_WIDTH (AXI_DATA_WIDTH)
    ) u_serdes (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (req_hs),
        .w_adv_i     (w_hs),
        .r_adv_i     (r_hs),
        .wdata_i     (wdata_q),
        .wstrb_i     (wstrb_q),
        .r_beat_i    (bus.in_miso_i.rdata),
        .w_beat_o    (w_beat),
        .w_strb_o    (w_strb),
        .last_beat_o (last_beat),
        .rdata_o     (rdata)
    );

`ifdef SR_AXI_ADAPTER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_q, to_d;
    logic            to_active, any_hs;

    assign to_active = state_q inside {StWrite, StWaitB, StReadAr, StReadR};
    assign any_hs    = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign timeout   = to_active && !any_hs && (to_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_d = to_q + 1'b1;
        if (!to_active || any_hs || timeout) begin
            to_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_hs) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = 1'b0;
                    state_d   = bus.mem_wr_i ? StWrite : StReadAr;
                end
            end
            StWrite: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs && last_beat) w_done_d = 1'b1;
                if (aw_done_d && w_done_d) state_d = StWaitB;
            end
            StWaitB: begin
                if (b_hs) begin
                    if (bus.in_miso_i.bresp != OKAY) err_d = 1'b1;
                    state_d = StResp;
                end
            end
            StReadAr: begin
                if (ar_hs) state_d = StReadR;
            end
            StReadR: begin
                if (r_hs) begin
                    if (bus.in_miso_i.rresp != OKAY) err_d = 1'b1;
                    if (bus.in_miso_i.rlast) begin
                        if (!last_beat) err_d = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                if (bus.mem_resp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (timeout) begin
            err_d   = 1'b1;
            state_d = StResp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (req_hs) begin
            addr_q  <= bus.mem_addr_i;
            wdata_q <= bus.mem_wdata_i;
            wstrb_q <= bus.mem_wstrb_i;
        end
    end

    always_comb begin
        mosi         = '0;
        mosi.awid    = AXI_ID_W'(axi_id);
        mosi.awaddr  = AXI_ADDR_W'(addr_q);
        mosi.awlen   = 8'(BEATS - 1);
        mosi.awsize  = axi_size(AXI_DATA_WIDTH);
        mosi.awburst = INCR;
        mosi.awvalid = aw_valid;
        mosi.wdata   = w_beat;
        mosi.wstrb   = w_strb;
        mosi.wlast   = last_beat;
        mosi.wvalid  = w_valid;
        mosi.bready  = state_q inside {StIdle, StWaitB, StResp};
        mosi.arid    = AXI_ID_W'(axi_id);
        mosi.araddr  = AXI_ADDR_W'(addr_q);
        mosi.arlen   = 8'(BEATS - 1);
        mosi.arsize  = axi_size(AXI_DATA_WIDTH);
        mosi.arburst = INCR;
        mosi.arvalid = ar_valid;
        mosi.rready  = state_q inside {StIdle, StReadR, StResp};
    end

    assign bus.in_mosi_o        = mosi;
    assign bus.mem_req_ready_o  = (state_q == StIdle) && !rst;
    assign bus.mem_resp_valid_o = (state_q == StResp);
    assign bus.mem_rdata_o      = rdata;
    assign bus.mem_resp_err_o   = err_q;

endmodule
